// File: rtl/fp_divsqrt_fu.sv
// fp_divsqrt_fu: multi-cycle IEEE-754 divide / square root using a radix-2 restoring iteration.
// Subnormal operands are flushed to signed zero; results below the normal range flush to zero.
module fp_divsqrt_fu #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            start,
    input  logic            is_sqrt,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    input  logic [2:0]      rm,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [FLEN-1:0] result,
    output logic [4:0]      fflags
);
    localparam int N     = MAN_W + 3;
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam int REM_W = MAN_W + 5;
    localparam int SE_W  = EXP_W + 3;
    localparam logic signed [SE_W-1:0] BIAS = SE_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [SE_W-1:0] EMAX = SE_W'((1 << EXP_W) - 1);
    localparam logic signed [SE_W-1:0] ONE  = SE_W'(1);
    localparam logic [FLEN-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;
    state_t state, state_nx;

    logic [FLEN-1:0]         a_q, b_q;
    logic                    sqrt_q;
    logic [2:0]              rm_q;
    logic [REM_W-1:0]        rem;
    logic [2*N-1:0]          xrad;
    logic [MAN_W:0]          divs;
    logic [N-1:0]            quo;
    logic [CNT_W-1:0]        cnt;
    logic signed [SE_W-1:0]  exp_r;
    logic                    sign_r;

    // operand unpacking and classification
    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        ma, mb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [MAN_W:0]          siga, sigb;
    logic signed [SE_W-1:0]  ea_x, eb_x, e_unb;
    logic [MAN_W+1:0]        sqrt_sig;

    assign {sa, ea, ma} = a_q;
    assign {sb, eb, mb} = b_q;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (ma != '0);
    assign b_nan  = (&eb) && (mb != '0);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    assign siga   = {1'b1, ma};
    assign sigb   = {1'b1, mb};
    assign ea_x   = {{(SE_W-EXP_W){1'b0}}, ea};
    assign eb_x   = {{(SE_W-EXP_W){1'b0}}, eb};
    assign e_unb  = ea_x - BIAS;
    // odd exponent: fold one factor of two into the radicand so the halved exponent is exact
    assign sqrt_sig = e_unb[0] ? {siga, 1'b0} : {1'b0, siga};

    logic             spec_hit;
    logic [FLEN-1:0]  spec_res;
    logic [4:0]       spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = QNAN;
        spec_flags = '0;
        if (sqrt_q) begin
            if (a_nan)       spec_flags[4] = a_snan;
            else if (a_zero) spec_res = {sa, {(FLEN-1){1'b0}}};
            else if (sa)     spec_flags[4] = 1'b1;
            else if (a_inf)  spec_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else             spec_hit = 1'b0;
        end else begin
            if (a_nan || b_nan) begin
                spec_flags[4] = a_snan | b_snan;
            end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                spec_flags[4] = 1'b1;
            end else if (a_inf) begin
                spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (b_zero) begin
                spec_res      = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_flags[3] = 1'b1;
            end else if (b_inf || a_zero) begin
                spec_res = {sa ^ sb, {(FLEN-1){1'b0}}};
            end else begin
                spec_hit = 1'b0;
            end
        end
    end

    // one restoring step: quotient bit for division, root bit for square root
    logic [REM_W-1:0] cand, trial, diff, rem_next;
    logic             ge;

    always_comb begin
        if (sqrt_q) begin
            cand  = {rem[REM_W-3:0], xrad[2*N-1 -: 2]};
            trial = {quo, 2'b01};
        end else begin
            cand  = rem;
            trial = {{(REM_W-MAN_W-1){1'b0}}, divs};
        end
        ge       = (cand >= trial);
        diff     = ge ? cand - trial : cand;
        rem_next = sqrt_q ? diff : {diff[REM_W-2:0], 1'b0};
    end

    // rounding and range check
    logic                    lead, g, r, st, nx, inc, to_inf;
    logic [MAN_W-1:0]        man;
    logic [MAN_W:0]          sum;
    logic signed [SE_W-1:0]  e_n, e_f;
    logic [FLEN-1:0]         rnd_res;
    logic [4:0]              rnd_flags;

    always_comb begin
        lead = quo[N-1];
        if (lead) begin
            man = quo[N-2:2];
            g   = quo[1];
            r   = quo[0];
            e_n = exp_r;
        end else begin
            man = quo[N-3:1];
            g   = quo[0];
            r   = 1'b0;
            e_n = exp_r - ONE;
        end
        st = (rem != '0);
        nx = g | r | st;
        case (rm_q)
            3'b001:  begin inc = 1'b0;          to_inf = 1'b0;    end
            3'b010:  begin inc = sign_r & nx;   to_inf = sign_r;  end
            3'b011:  begin inc = ~sign_r & nx;  to_inf = ~sign_r; end
            3'b100:  begin inc = g;             to_inf = 1'b1;    end
            default: begin inc = g & (r | st | man[0]); to_inf = 1'b1; end
        endcase
        sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        e_f = sum[MAN_W] ? e_n + ONE : e_n;
        rnd_flags = {4'b0000, nx};
        rnd_res   = {sign_r, e_f[EXP_W-1:0], sum[MAN_W-1:0]};
        if (e_f >= EMAX) begin
            rnd_flags = 5'b00101;
            if (to_inf) rnd_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else        rnd_res = {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (e_f < ONE) begin
            rnd_flags = 5'b00011;
            rnd_res   = {sign_r, {(FLEN-1){1'b0}}};
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE:  if (start && !abort) state_nx = S_PREP;
            S_PREP:  begin busy = 1'b1; state_nx = spec_hit ? S_DONE : S_ITER; end
            S_ITER:  begin busy = 1'b1; if (cnt == CNT_W'(N - 1)) state_nx = S_ROUND; end
            S_ROUND: begin busy = 1'b1; state_nx = S_DONE; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; state_nx = S_IDLE; end
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            a_q    <= '0;
            b_q    <= '0;
            sqrt_q <= 1'b0;
            rm_q   <= '0;
            rem    <= '0;
            xrad   <= '0;
            divs   <= '0;
            quo    <= '0;
            cnt    <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            result <= '0;
            fflags <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        a_q    <= a;
                        b_q    <= b;
                        sqrt_q <= is_sqrt;
                        rm_q   <= rm;
                    end
                end
                S_PREP: begin
                    cnt  <= '0;
                    quo  <= '0;
                    divs <= sigb;
                    if (sqrt_q) begin
                        rem    <= '0;
                        xrad   <= {sqrt_sig, {(MAN_W+4){1'b0}}};
                        exp_r  <= (e_unb >>> 1) + BIAS;
                        sign_r <= 1'b0;
                    end else begin
                        rem    <= {{(REM_W-MAN_W-1){1'b0}}, siga};
                        xrad   <= '0;
                        exp_r  <= ea_x - eb_x + BIAS;
                        sign_r <= sa ^ sb;
                    end
                end
                S_ITER: begin
                    rem  <= rem_next;
                    quo  <= {quo[N-2:0], ge};
                    xrad <= xrad << 2;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
            if (!abort) begin
                if (state == S_PREP && spec_hit) begin
                    result <= spec_res;
                    fflags <= spec_flags;
                end else if (state == S_ROUND) begin
                    result <= rnd_res;
                    fflags <= rnd_flags;
                end
            end
        end
    end
endmodule

// File: doc/fp_divsqrt_fu.md
# fp_divsqrt_fu

Multi-cycle, parametrised IEEE-754 divide / square-root unit for the F (and later D) extension. It sits beside the single-precision FP functional unit in the execute stage and takes over FDIV and FSQRT, which cannot close timing combinationally. It uses a start/done handshake. The result is computed by a radix-2 restoring iteration, rounded in all five RISC-V rounding modes, and returned with fflags.

## Interface
- EXP_W, default 8: exponent width. Use 11 for double precision.
- MAN_W, default 23: stored mantissa width. Use 52 for double precision.
- FLEN, default 1+EXP_W+MAN_W: operand width. Derived; do not override.
- clk_in  in  1  system clock. All state changes on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- is_sqrt  in  1  selects the operation. 0 computes a/b; 1 computes sqrt(a), and b is ignored.
- a  in  FLEN  dividend, or radicand when is_sqrt=1.
- b  in  FLEN  divisor.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Codes 101–111 are illegal and behave as RNE.
- abort  in  1  pipeline flush. Cancels any operation in flight.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted (inclusive).
- done  out  1  one-cycle pulse. result and fflags are valid in that cycle.
- result  out  FLEN  rounded result. Held until the next done.
- fflags  out  5  {NV,DZ,OF,UF,NX}. Held with result.

## Operation
- States: IDLE → PREP → ITER → ROUND → DONE → IDLE.
- IDLE
  - If start=1 and abort=0, latch a, b, is_sqrt and rm, then go to PREP.
  - start is ignored in every other state. There is no queueing.
- PREP (1 cycle)
  - Unpack the operands.
  - Subnormal inputs are flushed to signed zero. This is a documented deviation, and it does not set any flag.
  - Detect special cases. Any special case goes directly to DONE, skipping ITER and ROUND.
- Special cases for division:
  - NaN input, 0/0 or inf/inf: result 0x7FC00000 (canonical NaN, generalised to FLEN). NV is set, except that a quiet-NaN input alone does not set NV.
  - Finite non-zero x/0: signed inf, DZ.
  - inf/finite: signed inf, no flags.
  - Finite/inf, or 0/finite non-zero: signed zero, no flags.
- Special cases for square root:
  - NaN input: canonical NaN; NV only if the NaN is signalling.
  - Negative non-zero input, including -inf: canonical NaN, NV.
  - ±0: returns the same ±0.
  - +inf: returns +inf.
- Normal path, division:
  - Result exponent = ea − eb + bias.
  - Quotient significand = 1.ma / 1.mb, computed as MAN_W+3 quotient bits.
  - If the leading bit is 0, normalise left by 1 and decrement the exponent.
- Normal path, square root:
  - If the unbiased exponent is odd, shift the significand left by 1.
  - Result exponent = (unbiased exponent >> 1) + bias, using arithmetic shift.
  - Root is MAN_W+3 bits.
- ITER: exactly MAN_W+3 cycles, one result bit per cycle, tracked by an iteration counter of width clog2(MAN_W+4).
- ROUND (1 cycle)
  - Guard and round bits come from the iteration; sticky = (remainder != 0).
  - Apply rm, then renormalise if the increment carried out.
  - Overflow (exponent ≥ all-ones): OF and NX are set. The result is inf for RNE, RMM, and the directed mode toward the sign; otherwise it is the largest finite number of that sign.
  - Underflow (exponent ≤ 0 after rounding): result is signed zero, with UF and NX set. This is FTZ.
  - NX is set whenever guard, round or sticky is non-zero.
  - Sign of the result: sa^sb for division; always + for square root.
- DONE: drive done=1 for one cycle, then go to IDLE.
- abort
  - In any state, abort forces the FSM to IDLE on the next edge, with busy=0 and no done pulse.
  - result and fflags keep their previous values.
  - abort together with start in IDLE: the start is dropped.
- Reset: state=IDLE, busy=0, done=0, result=0, fflags=0, counter=0.

## Timing
- Call the start cycle 0.
- Normal path: PREP in cycle 1; ITER in cycles 2..MAN_W+4; ROUND in cycle MAN_W+5; done in cycle MAN_W+6. For single precision that is cycle 29; for double precision, cycle 58.
- Special-case path: done in cycle 2.
- result and fflags are registered. They change only on the edge that enters DONE.
- Back-to-back: a new start may be presented in the cycle after done, when the FSM is back in IDLE. A start presented in the done cycle itself is ignored.
- busy rises in cycle 1 and falls after the done cycle.

## Test plan
- 0x40C00000 / 0x40000000, rm=RNE → result 0x40400000, fflags 0. done pulses exactly at cycle 29; busy is high in cycles 1–29.
- 0x3F800000 / 0x40400000:
  - rm=RNE → 0x3EAAAAAB, NX.
  - rm=RTZ → 0x3EAAAAAA, NX.
  - rm=RUP → 0x3EAAAAAB, NX.
- sqrt(0x40000000), RNE → 0x3FB504F3, NX.
  - sqrt(0x40800000) → 0x40000000, fflags 0.
  - sqrt(0xBF800000) → 0x7FC00000, NV, done at cycle 2.
- Special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000, DZ, done at cycle 2.
  - 0/0 → 0x7FC00000, NV.
  - 0xBF800000 / 0x00000000 → 0xFF800000, DZ.
- Overflow: 0x7F7FFFFF / 0x3F000000.
  - RNE → 0x7F800000, OF|NX.
  - RTZ → 0x7F7FFFFF, OF|NX.
- Control sequencing:
  - Assert abort at cycle 10 of a division → no done, busy=0 at cycle 11, and result keeps its prior value.
  - Pulse start again at cycle 5 of a running operation → it is ignored, and exactly one done occurs, at cycle 29.
  - Assert reset_in mid-ITER → all outputs go to 0 immediately, without waiting for a clock edge.
